// File: rtl/cache_control_nway_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_control_nway_pkg
//  Description : Shared types for the N-way cache controller. Holds the
//                controller state encoding used by cache_control_nway.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_control_nway_pkg;

    // Controller states. WB_GAP is a single dead cycle between the writeback
    // and the fill so pmem sees its request level drop between transfers.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        WB_GAP     = 2'd2,
        FILL       = 2'd3
    } cache_ctl_state_t;

endpackage : cache_control_nway_pkg
`default_nettype wire

// File: rtl/cache_victim_select.sv
`default_nettype none
// ============================================================================
//  Module      : cache_victim_select
//  Description : Chooses the way to replace on a miss. An invalid way is
//                always preferred (lowest index first); only when every way
//                is valid does the replacement policy's choice apply.
//  Ports       : valid      - per-way valid bits of the current set
//                lru_victim - way nominated by the replacement policy
//                victim     - selected way
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_victim_select #(
    parameter int NUM_WAYS = 4,
    parameter int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [WAY_W-1:0]    lru_victim,
    output logic [WAY_W-1:0]    victim
);

    logic w_found;

    always_comb begin
        victim  = lru_victim;
        w_found = 1'b0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!w_found && !valid[i]) begin
                victim  = WAY_W'(i);
                w_found = 1'b1;
            end
        end
    end

endmodule : cache_victim_select
`default_nettype wire

// File: rtl/cache_control_nway.sv
`default_nettype none
// ============================================================================
//  Module      : cache_control_nway
//  Description : Control FSM for a NUM_WAYS-way set-associative, write-back,
//                write-allocate cache. Hits complete in the request cycle;
//                misses optionally write back a dirty victim, fill the line,
//                then replay the access as a hit. Keeps saturating hit, miss
//                and writeback counters. Tag/data/valid/dirty arrays are
//                external; this block only produces their strobes.
//  Ports       : CPU side  - mem_read, mem_write, mem_resp
//                Set state - hit, valid, dirty, lru_victim
//                Array ctl - data_writeline, tag_write, valid_write/valid_in,
//                            dirty_write/dirty_in, wb_sel, lru_update/lru_way
//                pmem side - pmem_read, pmem_write, pmem_resp,
//                            pmem_addr_sel, pmem_way
//                Stats     - hit_cnt, miss_cnt, wb_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_control_nway
    import cache_control_nway_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int CNT_W    = 32,
    parameter int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [NUM_WAYS-1:0] hit,
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [NUM_WAYS-1:0] dirty,
    input  logic [WAY_W-1:0]    lru_victim,
    input  logic                pmem_resp,
    output logic [NUM_WAYS-1:0] data_writeline,
    output logic [NUM_WAYS-1:0] tag_write,
    output logic [NUM_WAYS-1:0] valid_write,
    output logic                valid_in,
    output logic [NUM_WAYS-1:0] dirty_write,
    output logic                dirty_in,
    output logic                wb_sel,
    output logic                lru_update,
    output logic [WAY_W-1:0]    lru_way,
    output logic                pmem_addr_sel,
    output logic [WAY_W-1:0]    pmem_way,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic                mem_resp,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt,
    output logic [CNT_W-1:0]    wb_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    cache_ctl_state_t r_state, w_state_nxt;
    logic [WAY_W-1:0] r_victim;
    logic             r_replay;
    logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;

    logic             w_req;
    logic             w_any_hit;
    logic [WAY_W-1:0] w_hit_way;
    logic             w_hit_found;
    logic [WAY_W-1:0] w_victim;
    logic             w_miss_start;
    logic             w_hit_count;
    logic             w_wb_done;

    assign w_req     = mem_read | mem_write;
    assign w_any_hit = |hit;

    // Lowest-index hitting way; multiple hits are an upstream fault.
    always_comb begin
        w_hit_way   = '0;
        w_hit_found = 1'b0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!w_hit_found && hit[i]) begin
                w_hit_way   = WAY_W'(i);
                w_hit_found = 1'b1;
            end
        end
    end

    cache_victim_select #(
        .NUM_WAYS (NUM_WAYS),
        .WAY_W    (WAY_W)
    ) u_victim_select (
        .valid      (valid),
        .lru_victim (lru_victim),
        .victim     (w_victim)
    );

    assign w_miss_start = (r_state == IDLE) && w_req && !w_any_hit;
    // The hit that completes a replayed miss was already counted as a miss.
    assign w_hit_count  = (r_state == IDLE) && w_req && w_any_hit && !r_replay;
    assign w_wb_done    = (r_state == WRITE_BACK) && pmem_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_victim   <= '0;
            r_replay   <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Victim is frozen for the whole miss even if lru_victim moves.
            if (w_miss_start) begin
                r_victim <= w_victim;
            end
            if ((r_state == FILL) && pmem_resp) begin
                r_replay <= 1'b1;
            end else if (r_state == IDLE) begin
                r_replay <= 1'b0;
            end
            if (w_hit_count && (r_hit_cnt != c_cnt_max)) begin
                r_hit_cnt <= r_hit_cnt + c_cnt_one;
            end
            if (w_miss_start && (r_miss_cnt != c_cnt_max)) begin
                r_miss_cnt <= r_miss_cnt + c_cnt_one;
            end
            if (w_wb_done && (r_wb_cnt != c_cnt_max)) begin
                r_wb_cnt <= r_wb_cnt + c_cnt_one;
            end
        end
    end

    // Outputs are forced low while rst_n is asserted so a pmem transfer in
    // flight is abandoned in the same cycle reset arrives.
    always_comb begin
        w_state_nxt    = r_state;
        data_writeline = '0;
        tag_write      = '0;
        valid_write    = '0;
        valid_in       = 1'b0;
        dirty_write    = '0;
        dirty_in       = 1'b0;
        wb_sel         = 1'b0;
        lru_update     = 1'b0;
        lru_way        = '0;
        pmem_addr_sel  = 1'b0;
        pmem_way       = '0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        mem_resp       = 1'b0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (w_req && w_any_hit) begin
                        mem_resp   = 1'b1;
                        lru_update = 1'b1;
                        lru_way    = w_hit_way;
                        if (mem_write) begin
                            wb_sel                    = 1'b1;
                            data_writeline[w_hit_way] = 1'b1;
                            dirty_write[w_hit_way]    = 1'b1;
                            dirty_in                  = 1'b1;
                        end
                    end else if (w_req) begin
                        w_state_nxt = dirty[w_victim] ? WRITE_BACK : FILL;
                    end
                end
                WRITE_BACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    pmem_way      = r_victim;
                    if (pmem_resp) begin
                        w_state_nxt = WB_GAP;
                    end
                end
                WB_GAP: begin
                    w_state_nxt = FILL;
                end
                FILL: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        data_writeline[r_victim] = 1'b1;
                        tag_write[r_victim]      = 1'b1;
                        valid_write[r_victim]    = 1'b1;
                        dirty_write[r_victim]    = 1'b1;
                        valid_in                 = 1'b1;
                        lru_update               = 1'b1;
                        lru_way                  = r_victim;
                        w_state_nxt              = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
    assign wb_cnt   = r_wb_cnt;

endmodule : cache_control_nway
`default_nettype wire

// File: tb/tb_cache_control_nway.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_control_nway
//  Description : Scoreboard bench for cache_control_nway (4 ways). Stimulus
//                pushes expected CPU responses and line-fill strobes into
//                queues; a monitor pops and compares them whenever the DUT
//                asserts mem_resp or a tag write. A second instance with
//                4-bit counters shares the stimulus for saturation checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_control_nway;

    localparam int NW = 4;
    localparam int WW = 2;
    localparam int CW = 32;

    typedef struct packed {
        logic [WW-1:0] way;
        logic          wb_sel;
        logic [NW-1:0] dl;
        logic [NW-1:0] dw;
        logic          din;
    } resp_t;

    typedef struct packed {
        logic [NW-1:0] tw;
        logic [WW-1:0] way;
    } fill_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read, mem_write, pmem_resp;
    logic [NW-1:0] hit, valid, dirty;
    logic [WW-1:0] lru_victim;

    logic [NW-1:0] data_writeline, tag_write, valid_write, dirty_write;
    logic          valid_in, dirty_in, wb_sel, lru_update, pmem_addr_sel;
    logic [WW-1:0] lru_way, pmem_way;
    logic          pmem_read, pmem_write, mem_resp;
    logic [CW-1:0] hit_cnt, miss_cnt, wb_cnt;

    logic [NW-1:0] s_data_writeline, s_tag_write, s_valid_write, s_dirty_write;
    logic          s_valid_in, s_dirty_in, s_wb_sel, s_lru_update, s_pmem_addr_sel;
    logic [WW-1:0] s_lru_way, s_pmem_way;
    logic          s_pmem_read, s_pmem_write, s_mem_resp;
    logic [3:0]    s_hit_cnt, s_miss_cnt, s_wb_cnt;

    int checks   = 0;
    int failures = 0;

    resp_t exp_resp_q[$];
    fill_t exp_fill_q[$];

    always #5 clk = ~clk;

    cache_control_nway #(.NUM_WAYS(NW), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .hit(hit), .valid(valid), .dirty(dirty), .lru_victim(lru_victim),
        .pmem_resp(pmem_resp), .data_writeline(data_writeline),
        .tag_write(tag_write), .valid_write(valid_write), .valid_in(valid_in),
        .dirty_write(dirty_write), .dirty_in(dirty_in), .wb_sel(wb_sel),
        .lru_update(lru_update), .lru_way(lru_way), .pmem_addr_sel(pmem_addr_sel),
        .pmem_way(pmem_way), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .mem_resp(mem_resp), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    cache_control_nway #(.NUM_WAYS(NW), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .hit(hit), .valid(valid), .dirty(dirty), .lru_victim(lru_victim),
        .pmem_resp(pmem_resp), .data_writeline(s_data_writeline),
        .tag_write(s_tag_write), .valid_write(s_valid_write), .valid_in(s_valid_in),
        .dirty_write(s_dirty_write), .dirty_in(s_dirty_in), .wb_sel(s_wb_sel),
        .lru_update(s_lru_update), .lru_way(s_lru_way), .pmem_addr_sel(s_pmem_addr_sel),
        .pmem_way(s_pmem_way), .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
        .mem_resp(s_mem_resp), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt), .wb_cnt(s_wb_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every CPU response and every line fill in order.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mem_resp) begin
                if (exp_resp_q.size() == 0) begin
                    check("unexpected_mem_resp", 64'd1, 64'd0);
                end else begin
                    resp_t e;
                    e = exp_resp_q.pop_front();
                    check("resp", {lru_update, lru_way, wb_sel, data_writeline, dirty_write, dirty_in},
                          {1'b1, e.way, e.wb_sel, e.dl, e.dw, e.din});
                end
            end
            if (tag_write != '0) begin
                if (exp_fill_q.size() == 0) begin
                    check("unexpected_fill", {60'd0, tag_write}, 64'd0);
                end else begin
                    fill_t f;
                    f = exp_fill_q.pop_front();
                    check("fill", {tag_write, valid_write, data_writeline, dirty_write,
                                   valid_in, dirty_in, lru_update, lru_way, mem_resp},
                          {f.tw, f.tw, f.tw, f.tw, 1'b1, 1'b0, 1'b1, f.way, 1'b0});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit       = '0;
        pmem_resp = 1'b0;
    endtask

    function automatic resp_t rd(input logic [WW-1:0] w);
        rd = '{way: w, wb_sel: 1'b0, dl: '0, dw: '0, din: 1'b0};
    endfunction

    function automatic resp_t wr(input logic [WW-1:0] w);
        logic [NW-1:0] m;
        m  = '0;
        m[w] = 1'b1;
        wr = '{way: w, wb_sel: 1'b1, dl: m, dw: m, din: 1'b1};
    endfunction

    initial begin
        idle_in();
        rst_n      = 1'b0;
        valid      = 4'b1111;
        dirty      = 4'b0000;
        lru_victim = 2'd0;

        // Reset: outputs held low even with a hitting request presented.
        #12;
        mem_read = 1'b1;
        hit      = 4'b0001;
        #1;
        check("reset_outputs", {mem_resp, lru_update, pmem_read, pmem_write, wb_sel}, 5'b0);
        check("reset_counters", {hit_cnt, miss_cnt, wb_cnt}, 96'd0);
        idle_in();
        step();
        rst_n = 1'b1;
        step();

        // Read hit on way 2: same-cycle response, no pmem traffic.
        exp_resp_q.push_back(rd(2'd2));
        mem_read = 1'b1;
        hit      = 4'b0100;
        @(negedge clk);
        check("hit_no_pmem", {pmem_read, pmem_write, pmem_addr_sel}, 3'b000);
        step();
        idle_in();
        check("hit_cnt_1", hit_cnt, 1);

        // Write hit on way 0.
        exp_resp_q.push_back(wr(2'd0));
        mem_write = 1'b1;
        hit       = 4'b0001;
        step();
        idle_in();

        // Read and write together: write wins.
        exp_resp_q.push_back(wr(2'd1));
        mem_read  = 1'b1;
        mem_write = 1'b1;
        hit       = 4'b0010;
        step();
        idle_in();
        check("hit_cnt_3", hit_cnt, 3);

        // Clean read miss: way 2 is the first invalid way.
        valid = 4'b1011;
        exp_fill_q.push_back('{tw: 4'b0100, way: 2'd2});
        exp_resp_q.push_back(rd(2'd2));
        mem_read = 1'b1;
        step();
        @(negedge clk);
        check("fill_pmem", {pmem_read, pmem_write, pmem_addr_sel}, 3'b100);
        repeat (4) step();
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        hit       = 4'b0100;
        step();
        idle_in();
        check("clean_miss_cnts", {miss_cnt, hit_cnt}, {32'd1, 32'd3});

        // Dirty miss: LRU way 3 written back, stays way 3 though lru_victim moves.
        valid      = 4'b1111;
        dirty      = 4'b1000;
        lru_victim = 2'd3;
        exp_fill_q.push_back('{tw: 4'b1000, way: 2'd3});
        exp_resp_q.push_back(rd(2'd3));
        mem_read = 1'b1;
        step();
        lru_victim = 2'd1;
        @(negedge clk);
        check("wb_pmem", {pmem_read, pmem_write, pmem_addr_sel, pmem_way}, {3'b011, 2'd3});
        step();
        step();
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        @(negedge clk);
        check("wb_gap_idle", {pmem_read, pmem_write, pmem_addr_sel, mem_resp, lru_update}, 5'b0);
        check("wb_cnt_1", wb_cnt, 1);
        step();
        @(negedge clk);
        check("wb_then_fill", {pmem_read, pmem_write, pmem_addr_sel}, 3'b100);
        step();
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        hit       = 4'b1000;
        step();
        idle_in();
        lru_victim = 2'd0;
        dirty      = 4'b0000;
        check("dirty_miss_cnts", {miss_cnt, hit_cnt, wb_cnt}, {32'd2, 32'd3, 32'd1});

        // pmem_resp while idle is ignored.
        pmem_resp = 1'b1;
        @(negedge clk);
        check("stray_resp", {tag_write, data_writeline, valid_write, pmem_read, pmem_write}, 14'd0);
        step();
        pmem_resp = 1'b0;

        // Request dropped during the fill: fill completes, no CPU response.
        valid = 4'b0111;
        exp_fill_q.push_back('{tw: 4'b1000, way: 2'd3});
        mem_read = 1'b1;
        step();
        mem_read = 1'b0;
        step();
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        hit       = 4'b1000;
        @(negedge clk);
        check("dropped_no_resp", mem_resp, 1'b0);
        step();
        exp_resp_q.push_back(rd(2'd3));
        mem_read = 1'b1;
        step();
        idle_in();
        check("after_drop_cnts", {miss_cnt, hit_cnt}, {32'd3, 32'd4});

        // Reset asserted mid-fill.
        valid    = 4'b1110;
        mem_read = 1'b1;
        step();
        @(negedge clk);
        check("pre_reset_fill", pmem_read, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_fill", {pmem_read, pmem_write}, 2'b00);
        check("reset_mid_cnts", {hit_cnt, miss_cnt, wb_cnt}, 96'd0);
        idle_in();
        step();
        rst_n = 1'b1;
        valid = 4'b1111;
        step();

        // Back in IDLE: a hit responds at once, then saturation run.
        for (int i = 0; i < 18; i++) begin
            exp_resp_q.push_back(rd(2'd0));
            mem_read = 1'b1;
            hit      = 4'b0001;
            step();
            if (i == 0)  check("post_reset_hit", hit_cnt, 1);
            if (i == 13) check("sat_cnt_14", s_hit_cnt, 4'hE);
        end
        idle_in();
        check("hit_cnt_18", hit_cnt, 18);
        check("sat_hold", s_hit_cnt, 4'hF);
        step();
        step();

        check("resp_queue_empty", exp_resp_q.size(), 0);
        check("fill_queue_empty", exp_fill_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cache_control_nway
`default_nettype wire
